// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared state and owner encodings for the unified memory port
//            arbiter and its round-robin picker.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_ISSUE = ISSUE,
        ST_WAIT  = WAIT,
        ST_RESP  = RESP
    } arb_state_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_rr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_rr
// Purpose  : Combinational two-way round-robin picker between the fetch and
//            data requesters; a tie goes to whoever did not own the port last.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = if_req | d_req;
        grant_owner = OWN_IF;
        if (if_req && d_req) begin
            grant_owner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
        end else if (d_req) begin
            grant_owner = OWN_D;
        end
    end

endmodule : mem_arb_rr
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one fixed-latency memory port between instruction fetch
//            and load/store requesters, one access at a time.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Counter reaches zero in the cycle mem_rdata becomes valid.
    localparam logic [3:0] c_lat_init = 4'(MEM_LAT - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_owner;
    logic              r_last_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_lat_cnt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_grant_valid;
    logic              w_grant_owner;

    mem_arb_rr u_rr (
        .if_req      (if_req),
        .d_req       (d_req),
        .last_owner  (r_last_owner),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        if_valid    = 1'b0;
        d_valid     = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en      = 1'b1;
                mem_we      = r_we;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_lat_cnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if_valid    = (r_owner == OWN_IF);
                d_valid     = (r_owner == OWN_D);
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_IF;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_lat_cnt    <= 4'd0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Requester inputs are only ever sampled here.
                    if (w_grant_valid) begin
                        r_owner <= w_grant_owner;
                        if (w_grant_owner == OWN_D) begin
                            r_addr  <= d_addr;
                            r_we    <= d_we;
                            r_wdata <= d_wdata;
                        end else begin
                            r_addr  <= if_addr;
                            r_we    <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_lat_cnt <= c_lat_init;
                end
                ST_WAIT: begin
                    if (r_lat_cnt == 4'd0) begin
                        if (!r_we) begin
                            if (r_owner == OWN_IF) begin
                                r_if_rdata <= mem_rdata;
                            end else begin
                                r_d_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_last_owner <= r_owner;
                end
                default: begin
                    r_lat_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed and random stimulus for mem_port_arbiter against a
//            transaction-level reference model; second instance with MEM_LAT=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int   LAT    = 2;
    localparam logic T_IF   = 1'b0;
    localparam logic T_D    = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_valid, d_valid, mem_en, mem_we, busy;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        if_req1;
    logic [15:0] if_addr1;
    logic        if_valid1, d_valid1, mem_en1, mem_we1, busy1;
    logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_valid(if_valid1), .if_rdata(if_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
        .d_valid(d_valid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    // Read-only memory contents; address 0x0010 holds the fetch test word.
    function automatic logic [15:0] rom(input logic [15:0] a);
        if (a == 16'h0010) return 16'h1234;
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    logic [15:0] pipe [LAT];
    logic [15:0] pipe1;
    always @(posedge clk) begin
        pipe[0] <= mem_en ? rom(mem_addr) : 16'hDEAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        pipe1 <= mem_en1 ? rom(mem_addr1) : 16'hDEAD;
    end
    assign mem_rdata  = pipe[LAT-1];
    assign mem_rdata1 = pipe1;

    // Transaction-level model: a grant at cycle s owns the port through s+2+LAT.
    int          cyc = 0;
    bit          m_active = 0;
    int          m_start = 0;
    logic        m_owner = T_IF;
    logic        m_last = T_IF;
    logic        m_we = 1'b0;
    logic [15:0] m_addr = '0, m_wdata = '0;
    logic [15:0] m_if_rdata = '0, m_d_rdata = '0;
    bit          ev_if = 0, ev_d = 0;
    int          n_en = 0, en_cyc = 0;
    logic        grant_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic arb();
        if (rst) begin
            m_active   = 0;
            m_last     = T_IF;
            m_if_rdata = '0;
            m_d_rdata  = '0;
        end else if (!m_active && (if_req || d_req)) begin
            if (if_req && d_req) m_owner = ~m_last;
            else                 m_owner = d_req ? T_D : T_IF;
            m_addr   = (m_owner == T_D) ? d_addr : if_addr;
            m_we     = (m_owner == T_D) && d_we;
            m_wdata  = d_wdata;
            m_last   = m_owner;
            m_active = 1;
            m_start  = cyc;
            grant_q.push_back(m_owner);
        end
    endtask

    task automatic tick();
        int   ph;
        logic e_en, e_busy;
        @(posedge clk);
        #1;
        cyc++;
        ev_if = 0;
        ev_d  = 0;
        if (m_active && (cyc - m_start) == 3 + LAT) m_active = 0;
        ph     = m_active ? (cyc - m_start) : 0;
        e_busy = m_active && (ph >= 1);
        e_en   = m_active && (ph == 1);
        if (m_active && ph == 2 + LAT) begin
            if (m_owner == T_IF) begin
                ev_if      = 1;
                m_if_rdata = rom(m_addr);
            end else begin
                ev_d = 1;
                if (!m_we) m_d_rdata = rom(m_addr);
            end
        end
        if (mem_en) begin
            n_en++;
            en_cyc = cyc;
        end
        chk("busy", busy, e_busy);
        chk("mem_en", mem_en, e_en);
        chk("if_valid", if_valid, ev_if);
        chk("d_valid", d_valid, ev_d);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("d_rdata", d_rdata, m_d_rdata);
        chk("valid_excl", if_valid & d_valid, 0);
        if (e_en) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic cycle();
        arb();
        tick();
    endtask

    // Runs until the named requester completes; drops each requester on its valid.
    task automatic run_until_valid(input logic who, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget && at < 0; k++) begin
            cycle();
            if (ev_if) if_req = 1'b0;
            if (ev_d)  d_req  = 1'b0;
            if ((who == T_IF && ev_if) || (who == T_D && ev_d)) at = cyc;
        end
    endtask

    initial begin
        int   t0, a1, a2;
        logic order [4];
        int   n_seen;

        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        if_req1 = 1'b0; if_addr1 = '0;
        cycle();
        cycle();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_busy_lat1", busy1, 0);
        rst = 1'b0;
        cycle();

        // Single fetch
        if_req = 1'b1; if_addr = 16'h0010; t0 = cyc; n_en = 0;
        run_until_valid(T_IF, 20, a1);
        chk("fetch_valid_cycle", a1 - t0, 4);
        chk("fetch_en_cycle", en_cyc - t0, 1);
        chk("fetch_rdata", if_rdata, 16'h1234);
        cycle();

        // Store
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF; t0 = cyc; n_en = 0;
        run_until_valid(T_D, 20, a1);
        chk("store_valid_cycle", a1 - t0, 4);
        chk("store_en_count", n_en, 1);
        chk("store_d_rdata", d_rdata, 0);
        d_we = 1'b0;
        cycle();

        // Simultaneous requests straight out of reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        grant_q.delete();
        n_en = 0;
        if_req = 1'b1; if_addr = 16'h0040; d_req = 1'b1; d_addr = 16'h0300; d_we = 1'b0;
        run_until_valid(T_D, 20, a1);
        run_until_valid(T_IF, 20, a2);
        chk("tie_spacing", a2 - a1, 5);
        chk("tie_en_count", n_en, 2);
        chk("tie_grants", grant_q.size(), 2);
        chk("tie_first", grant_q[0], T_D);
        cycle();

        // Both held for four transactions
        n_seen = 0;
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 60 && n_seen < 4; k++) begin
            cycle();
            if (ev_if || ev_d) begin
                order[n_seen] = ev_d ? T_D : T_IF;
                n_seen++;
                if_addr = 16'($urandom);
                d_addr  = 16'($urandom);
                if (n_seen == 4) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end
        end
        chk("rr_count", n_seen, 4);
        chk("rr_order0", order[0], T_D);
        chk("rr_order1", order[1], T_IF);
        chk("rr_order2", order[2], T_D);
        chk("rr_order3", order[3], T_IF);
        cycle();

        // Reset while a load sits in WAIT
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0123;
        cycle();
        cycle();
        cycle();
        rst = 1'b1; d_req = 1'b0;
        cycle();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_mem_en", mem_en, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_d_valid", d_valid, 0);
        chk("abort_d_rdata", d_rdata, 0);
        chk("abort_if_rdata", if_rdata, 0);
        for (int k = 0; k < 4; k++) cycle();
        d_req = 1'b1; t0 = cyc;
        run_until_valid(T_D, 20, a1);
        chk("reissue_valid_cycle", a1 - t0, 4);
        chk("reissue_rdata", d_rdata, rom(16'h0123));

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = 16'($urandom);
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
            end
            cycle();
            rst = 1'b0;
            if (ev_if) if_req = 1'b0;
            if (ev_d)  d_req  = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k < 8; k++) cycle();

        // MEM_LAT=1 instance: fetch completes one cycle sooner
        if_req1 = 1'b1; if_addr1 = 16'h0010;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            chk("lat1_mem_en", mem_en1, (k == 1));
            chk("lat1_if_valid", if_valid1, (k == 3));
            if (k == 3) begin
                chk("lat1_if_rdata", if_rdata1, 16'h1234);
                if_req1 = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
